// File: rtl/cae_csr_pkg.sv
// Shared definitions for the CAE CSR bank: slot modes, default widths and
// the mask-to-mode mapping used when the bank elaborates its slots.
package cae_csr_pkg;

   localparam int unsigned CSR_DATA_W    = 64;
   localparam int unsigned CSR_ADDR_W    = 16;
   localparam int unsigned CSR_MAX_REGS  = 16;
   localparam logic [15:0] CSR_ADDR_BASE = 16'h0001;

   typedef enum logic [1:0] {
      CSR_MODE_RW  = 2'd0,
      CSR_MODE_RO  = 2'd1,
      CSR_MODE_W1C = 2'd2
   } csr_mode_e;

   // Read-only takes precedence; the bank rejects overlapping masks anyway.
   function automatic csr_mode_e csr_mode_from_mask(
      input logic [CSR_MAX_REGS-1:0] ro_mask,
      input logic [CSR_MAX_REGS-1:0] w1c_mask,
      input logic [3:0]              slot
   );
      if (ro_mask[slot])
         return CSR_MODE_RO;
      else if (w1c_mask[slot])
         return CSR_MODE_W1C;
      else
         return CSR_MODE_RW;
   endfunction

endpackage

// File: rtl/cae_csr_slot.sv
// One CSR slot: storage, mode-specific next-state logic and a read value
// that is zero unless the slot is selected.
module cae_csr_slot
   import cae_csr_pkg::*;
#(
   parameter csr_mode_e   MODE   = CSR_MODE_RW,
   parameter int unsigned DATA_W = CSR_DATA_W
) (
   input  logic              clk_csr,
   input  logic              i_csr_reset_n,
   input  logic              wr_en,
   input  logic              rd_sel,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] hw_in,
   input  logic [DATA_W-1:0] hw_set,
   output logic [DATA_W-1:0] rd_val,
   output logic [DATA_W-1:0] value
);

   logic [DATA_W-1:0] q;
   logic [DATA_W-1:0] q_nxt;

   // hw_set is ORed in last so a set beats a same-cycle clear.
   always_comb begin
      q_nxt = q;
      case (MODE)
         CSR_MODE_RW:  if (wr_en) q_nxt = wr_data;
         CSR_MODE_W1C: q_nxt = (wr_en ? (q & ~wr_data) : q) | hw_set;
         default:      q_nxt = '0;
      endcase
   end

   always_ff @(posedge clk_csr) begin
      if (!i_csr_reset_n)
         q <= '0;
      else
         q <= q_nxt;
   end

   always_comb begin
      rd_val = '0;
      if (rd_sel)
         rd_val = (MODE == CSR_MODE_RO) ? hw_in : q;
   end

   assign value = q;

endmodule

// File: rtl/cae_csr_bank.sv
// Parametrised CSR bank on the csr ring agent function interface: shared
// address decode, NUM_REGS slots, registered ack, read data and write strobes.
module cae_csr_bank
   import cae_csr_pkg::*;
#(
   parameter int unsigned             NUM_REGS  = 8,
   parameter int unsigned             DATA_W    = CSR_DATA_W,
   parameter int unsigned             ADDR_W    = CSR_ADDR_W,
   parameter logic [ADDR_W-1:0]       ADDR_BASE = ADDR_W'(CSR_ADDR_BASE),
   parameter logic [CSR_MAX_REGS-1:0] RO_MASK   = 16'b0000_0000_0000_0011,
   parameter logic [CSR_MAX_REGS-1:0] W1C_MASK  = 16'b0000_0000_0000_1000
) (
   input  logic                       clk_csr,
   input  logic                       i_csr_reset_n,
   input  logic                       func_wr_vld,
   input  logic                       func_rd_vld,
   input  logic [ADDR_W-1:0]          func_address,
   input  logic [DATA_W-1:0]          func_wr_data,
   output logic                       func_ack,
   output logic [DATA_W-1:0]          func_rd_data,
   input  logic [NUM_REGS*DATA_W-1:0] hw_in,
   input  logic [NUM_REGS*DATA_W-1:0] hw_set,
   output logic [NUM_REGS*DATA_W-1:0] csr_out,
   output logic [NUM_REGS-1:0]        csr_wr_strobe
);

   localparam logic [CSR_MAX_REGS-1:0] VALID_MASK =
      CSR_MAX_REGS'((33'd1 << NUM_REGS) - 33'd1);

   if (NUM_REGS < 1 || NUM_REGS > CSR_MAX_REGS) begin : g_bad_num_regs
      $error("cae_csr_bank: NUM_REGS must be in 1..16");
   end
   if ((RO_MASK & W1C_MASK & VALID_MASK) != '0) begin : g_bad_masks
      $error("cae_csr_bank: RO_MASK and W1C_MASK overlap");
   end

   // Modular subtraction: addresses below ADDR_BASE wrap high and miss.
   logic [ADDR_W-1:0] idx;
   logic              in_range;
   assign idx      = func_address - ADDR_BASE;
   assign in_range = idx < ADDR_W'(NUM_REGS);

   logic [NUM_REGS-1:0] hit;
   logic [NUM_REGS-1:0] wr_hit;
   logic [DATA_W-1:0]   slot_rd [NUM_REGS];
   logic [DATA_W-1:0]   rd_mux;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
      assign hit[i]    = in_range && (idx == ADDR_W'(i));
      assign wr_hit[i] = func_wr_vld & hit[i];

      cae_csr_slot #(
         .MODE   (csr_mode_from_mask(RO_MASK, W1C_MASK, 4'(i))),
         .DATA_W (DATA_W)
      ) u_slot (
         .clk_csr       (clk_csr),
         .i_csr_reset_n (i_csr_reset_n),
         .wr_en         (wr_hit[i]),
         .rd_sel        (hit[i]),
         .wr_data       (func_wr_data),
         .hw_in         (hw_in[i*DATA_W +: DATA_W]),
         .hw_set        (hw_set[i*DATA_W +: DATA_W]),
         .rd_val        (slot_rd[i]),
         .value         (csr_out[i*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)
         rd_mux = rd_mux | slot_rd[i];
   end

   always_ff @(posedge clk_csr) begin
      if (!i_csr_reset_n) begin
         func_ack      <= 1'b0;
         func_rd_data  <= '0;
         csr_wr_strobe <= '0;
      end else begin
         func_ack      <= func_rd_vld | func_wr_vld;
         func_rd_data  <= func_rd_vld ? rd_mux : '0;
         csr_wr_strobe <= wr_hit;
      end
   end

endmodule
